// File: rtl/sdram_arbiter.sv
// sdram_arbiter: shares the single SDRAM wrapper port between master 0 (CPU)
// and master 1 (e.g. disk DMA). One transaction is in flight at a time. The
// winner's request fields are registered toward the wrapper at grant time.
// Every transaction is followed by a RELEASE cycle and an IDLE cycle. This
// lets the wrapper's 2-stage ack delay line clear between back-to-back
// transactions.
//
// Configuration macro:
//   SDRAM_ARB_RR_EN  defined   -> round-robin on simultaneous requests
//                    undefined -> fixed priority, master 0 wins ties
//
// Ports:
//   clk_p, rst_n                 clock, synchronous active-low reset
//   mX_stb/we/sel/adr/wdat       master X request (X = 0, 1)
//   mX_ack, mX_rdat              master X completion and read data
//   sdram_ready                  wrapper initialisation done
//   sdram_stb/we/sel/adr/out     registered request to the wrapper
//   sdram_dat, sdram_ack         wrapper read data and combinational ack
//   grant                        one-hot current owner, 00 when idle
module sdram_arbiter #(
  parameter int ADDR_W = 21
) (
  input  logic            clk_p,
  input  logic            rst_n,
  input  logic            m0_stb,
  input  logic            m0_we,
  input  logic [1:0]      m0_sel,
  input  logic [ADDR_W:1] m0_adr,
  input  logic [15:0]     m0_wdat,
  output logic            m0_ack,
  output logic [15:0]     m0_rdat,
  input  logic            m1_stb,
  input  logic            m1_we,
  input  logic [1:0]      m1_sel,
  input  logic [ADDR_W:1] m1_adr,
  input  logic [15:0]     m1_wdat,
  output logic            m1_ack,
  output logic [15:0]     m1_rdat,
  input  logic            sdram_ready,
  output logic            sdram_stb,
  output logic            sdram_we,
  output logic [1:0]      sdram_sel,
  output logic [ADDR_W:1] sdram_adr,
  output logic [15:0]     sdram_out,
  input  logic [15:0]     sdram_dat,
  input  logic            sdram_ack,
  output logic [1:0]      grant
);

  typedef enum logic [1:0] {IDLE, BUSY0, BUSY1, RELEASE} state_t;
  state_t state;

  logic pick1;  // master 1 wins the IDLE evaluation

`ifdef SDRAM_ARB_RR_EN
  logic last_m1;  // 1 = master 1 was served last
  always_comb begin
    pick1 = 1'b0;
    pick1 = m1_stb & (~m0_stb | ~last_m1);
  end
`else
  always_comb begin
    pick1 = 1'b0;
    pick1 = m1_stb & ~m0_stb;
  end
`endif

  always_ff @(posedge clk_p) begin
    if (!rst_n) begin
      state     <= IDLE;
      sdram_stb <= 1'b0;
      sdram_we  <= 1'b0;
      sdram_sel <= 2'b00;
      sdram_adr <= '0;
      sdram_out <= 16'h0000;
      grant     <= 2'b00;
`ifdef SDRAM_ARB_RR_EN
      last_m1   <= 1'b1;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (sdram_ready && (m0_stb || m1_stb)) begin
            sdram_stb <= 1'b1;
            sdram_we  <= pick1 ? m1_we   : m0_we;
            sdram_sel <= pick1 ? m1_sel  : m0_sel;
            sdram_adr <= pick1 ? m1_adr  : m0_adr;
            sdram_out <= pick1 ? m1_wdat : m0_wdat;
            grant     <= pick1 ? 2'b10 : 2'b01;
            state     <= pick1 ? BUSY1 : BUSY0;
`ifdef SDRAM_ARB_RR_EN
            last_m1   <= pick1;
`endif
          end
        end
        BUSY0, BUSY1: begin
          // Runs to completion even if the owner drops stb or ready falls.
          if (sdram_ack) begin
            sdram_stb <= 1'b0;
            grant     <= 2'b00;
            state     <= RELEASE;
          end
        end
        default: state <= IDLE;  // RELEASE: dead cycle, requests ignored
      endcase
    end
  end

  // Ack is only returned to an owner still strobing.
  assign m0_ack  = sdram_ack & (state == BUSY0) & m0_stb;
  assign m1_ack  = sdram_ack & (state == BUSY1) & m1_stb;
  assign m0_rdat = sdram_dat;
  assign m1_rdat = sdram_dat;

endmodule

// File: tb/tb_sdram_arbiter.sv
module tb_sdram_arbiter;
  localparam int ADDR_W = 21;

  logic            clk_p = 1'b0;
  logic            rst_n;
  logic            m0_stb, m0_we, m1_stb, m1_we;
  logic [1:0]      m0_sel, m1_sel;
  logic [ADDR_W:1] m0_adr, m1_adr;
  logic [15:0]     m0_wdat, m1_wdat, m0_rdat, m1_rdat;
  logic            m0_ack, m1_ack;
  logic            sdram_ready, sdram_stb, sdram_we, sdram_ack;
  logic [1:0]      sdram_sel, grant;
  logic [ADDR_W:1] sdram_adr;
  logic [15:0]     sdram_out, sdram_dat;

  int checks = 0;
  int errors = 0;

  sdram_arbiter #(.ADDR_W(ADDR_W)) dut (
    .clk_p(clk_p), .rst_n(rst_n),
    .m0_stb(m0_stb), .m0_we(m0_we), .m0_sel(m0_sel), .m0_adr(m0_adr),
    .m0_wdat(m0_wdat), .m0_ack(m0_ack), .m0_rdat(m0_rdat),
    .m1_stb(m1_stb), .m1_we(m1_we), .m1_sel(m1_sel), .m1_adr(m1_adr),
    .m1_wdat(m1_wdat), .m1_ack(m1_ack), .m1_rdat(m1_rdat),
    .sdram_ready(sdram_ready), .sdram_stb(sdram_stb), .sdram_we(sdram_we),
    .sdram_sel(sdram_sel), .sdram_adr(sdram_adr), .sdram_out(sdram_out),
    .sdram_dat(sdram_dat), .sdram_ack(sdram_ack), .grant(grant)
  );

  always #5 clk_p = ~clk_p;

  task automatic tick();
    @(posedge clk_p);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int low;
    logic [1:0] exp_g;
    rst_n = 1'b0; sdram_ready = 1'b0; sdram_ack = 1'b0; sdram_dat = 16'h0;
    m0_stb = 0; m0_we = 0; m0_sel = 0; m0_adr = '0; m0_wdat = 0;
    m1_stb = 0; m1_we = 0; m1_sel = 0; m1_adr = '0; m1_wdat = 0;
    tick(); tick();

    // Reset state
    chk("rst_stb", 32'(sdram_stb), 0);
    chk("rst_grant", 32'(grant), 0);
    chk("rst_we", 32'(sdram_we), 0);
    chk("rst_sel", 32'(sdram_sel), 0);
    chk("rst_adr", 32'(sdram_adr), 0);
    chk("rst_out", 32'(sdram_out), 0);
    chk("rst_acks", {30'd0, m1_ack, m0_ack}, 0);
    rst_n = 1'b1;

    // Not ready: no grant for 10 cycles
    m0_stb = 1; m0_we = 1; m0_sel = 2'b10; m0_adr = 21'h12345; m0_wdat = 16'hA5C3;
    low = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (sdram_stb !== 1'b0 || grant !== 2'b00) low++;
    end
    chk("notready_nogrant_cycles", 32'(low), 0);

    // Ready: grant on next edge, M0 write latched
    sdram_ready = 1;
    tick();
    chk("m0w_stb", 32'(sdram_stb), 1);
    chk("m0w_grant", 32'(grant), 32'b01);
    m0_adr = 21'h00777; m0_wdat = 16'h1111; m0_sel = 2'b01; m0_we = 0;  // must be ignored
    tick();
    chk("m0w_adr_hold", 32'(sdram_adr), 32'h12345);
    tick();
    chk("m0w_sel_hold", 32'(sdram_sel), 32'b10);
    chk("m0w_out_hold", 32'(sdram_out), 32'hA5C3);
    chk("m0w_we_hold", 32'(sdram_we), 1);
    chk("m0w_noack_early", 32'(m0_ack), 0);
    sdram_ack = 1; #1;
    chk("m0w_ack", 32'(m0_ack), 1);
    chk("m0w_m1ack", 32'(m1_ack), 0);
    tick();
    sdram_ack = 0; m0_stb = 0; #1;
    chk("m0w_release_stb", 32'(sdram_stb), 0);
    chk("m0w_release_grant", 32'(grant), 0);
    chk("m0w_ack_single", 32'(m0_ack), 0);
    tick();
    chk("m0w_idle_stb", 32'(sdram_stb), 0);

    // M1 read
    m1_stb = 1; m1_we = 0; m1_sel = 2'b11; m1_adr = 21'h0ABCD; m1_wdat = 16'hDEAD;
    tick();
    chk("m1r_grant", 32'(grant), 32'b10);
    chk("m1r_adr", 32'(sdram_adr), 32'h0ABCD);
    chk("m1r_we", 32'(sdram_we), 0);
    sdram_dat = 16'h1F2E; sdram_ack = 1; #1;
    chk("m1r_ack", 32'(m1_ack), 1);
    chk("m1r_rdat", 32'(m1_rdat), 32'h1F2E);
    chk("m1r_m0ack", 32'(m0_ack), 0);
    tick();
    sdram_ack = 0; m1_stb = 0;
    tick();

    // Contention: 8 transactions, both masters requesting
    m0_stb = 1; m0_we = 1; m0_adr = 21'h00100;
    m1_stb = 1; m1_we = 0; m1_adr = 21'h00200;
    tick();
    for (int t = 0; t < 8; t++) begin
`ifdef SDRAM_ARB_RR_EN
      exp_g = (t % 2 == 0) ? 2'b01 : 2'b10;
`else
      exp_g = 2'b01;
`endif
      chk($sformatf("cont_stb_%0d", t), 32'(sdram_stb), 1);
      chk($sformatf("cont_grant_%0d", t), 32'(grant), 32'(exp_g));
      sdram_ack = 1; #1;
      chk($sformatf("cont_acks_%0d", t), {30'd0, m1_ack, m0_ack}, 32'(exp_g));
      tick();
      sdram_ack = 0;
      low = 0;
      while (!sdram_stb && low < 10) begin
        low++;
        tick();
      end
      if (t < 7) chk($sformatf("cont_gap_%0d", t), 32'(low), 2);
    end
    m0_stb = 0; m1_stb = 0;
    tick();  // the 9th transaction granted above stays open; close it
    sdram_ack = 1; tick(); sdram_ack = 0; tick(); tick();
    chk("cont_idle_stb", 32'(sdram_stb), 0);

    // M0 drops stb one cycle into BUSY0
    m0_stb = 1; m0_adr = 21'h00ABC;
    tick();
    chk("drop_grant", 32'(grant), 32'b01);
    tick();
    m0_stb = 0;
    tick();
    chk("drop_stb_held", 32'(sdram_stb), 1);
    chk("drop_grant_held", 32'(grant), 32'b01);
    sdram_ack = 1; #1;
    chk("drop_noack", {30'd0, m1_ack, m0_ack}, 0);
    tick();
    sdram_ack = 0;
    chk("drop_release_stb", 32'(sdram_stb), 0);
    chk("drop_release_grant", 32'(grant), 0);
    tick();
    chk("drop_idle_stb", 32'(sdram_stb), 0);

    // Reset during BUSY1
    m1_stb = 1; m1_adr = 21'h1FFFF;
    tick();
    chk("rb_grant", 32'(grant), 32'b10);
    rst_n = 0;
    tick();
    chk("rb_stb", 32'(sdram_stb), 0);
    chk("rb_grant0", 32'(grant), 0);
    sdram_ack = 1; #1;
    chk("rb_noack", 32'(m1_ack), 0);
    sdram_ack = 0; m1_stb = 0; rst_n = 1;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sdram_arbiter.md
# sdram_arbiter

Two-master arbiter that shares the board's single SDRAM controller port between the CPU bus (master 0) and a second bus master (master 1, e.g. disk DMA). It sits between the `topboard` SDRAM interface signals and the board-level SDRAM wrapper, which provides the `sdram_stb`/`sdram_ack` handshake. It holds one transaction at a time and registers the winning master's request toward SDRAM. It inserts the release cycle the wrapper's ack pipeline needs between back-to-back transactions.

## Interface

**Parameters**
- `ADDR_W`, default 21: word-address MSB; addresses are `[ADDR_W:1]`.

**Ports**
- `clk_p`  in  1  processor clock, all logic on rising edge
- `rst_n`  in  1  synchronous reset, active low
- `m0_stb`, `m1_stb`  in  1  master transaction request
- `m0_we`, `m1_we`  in  1  1 = write, 0 = read
- `m0_sel`, `m1_sel`  in  2  byte selects; bit1 = high byte, bit0 = low byte
- `m0_adr`, `m1_adr`  in  ADDR_W  word address `[ADDR_W:1]`
- `m0_wdat`, `m1_wdat`  in  16  write data
- `m0_ack`, `m1_ack`  out  1  transaction complete
- `m0_rdat`, `m1_rdat`  out  16  read data; both equal `sdram_dat`
- `sdram_ready`  in  1  SDRAM initialisation done
- `sdram_stb`  out  1  request to SDRAM wrapper
- `sdram_we`  out  1  write enable
- `sdram_sel`  out  2  byte selects
- `sdram_adr`  out  ADDR_W  address `[ADDR_W:1]`
- `sdram_out`  out  16  write data
- `sdram_dat`  in  16  read data
- `sdram_ack`  in  1  wrapper acknowledge; combinational, only valid while `sdram_stb` = 1
- `grant`  out  2  one-hot current owner; 00 when idle

## Operation

- FSM states:
  - IDLE: evaluate requests.
  - BUSY0 / BUSY1: master 0 or 1 owns the slave port.
  - RELEASE: one dead cycle.
- IDLE, `sdram_ready` = 0: stay in IDLE; no grant is issued.
- IDLE, `sdram_ready` = 1 and a request is present:
  - Latch the winner's `we`, `sel`, `adr` and `wdat` into the `sdram_*` output registers.
  - Go to BUSYx and set `grant` to that master.
- BUSYx: `sdram_stb` = 1. When `sdram_ack` = 1, go to RELEASE.
- RELEASE: `sdram_stb` = 0, `grant` = 00. Next state is IDLE; requests are ignored in this state.
- Master acknowledge: `mX_ack = sdram_ack & (state == BUSYx) & mX_stb`.
  - If the owning master drops `stb` before ack, the slave transaction still runs to completion.
  - In that case no ack is returned to that master.
- `sdram_ready` falling during BUSYx: the transaction still completes. Only new grants are blocked.
- Arbitration on simultaneous requests is set by the macro below. A single requester always wins.
- Latched request fields stay constant for the whole of BUSYx. Master-side changes after the grant are ignored.

## Timing

- Reset values:
  - state IDLE
  - `sdram_stb` 0, `sdram_we` 0, `sdram_sel` 00, `sdram_adr` 0, `sdram_out` 0
  - `grant` 00, `m0_ack`/`m1_ack` 0
  - round-robin pointer = master 1 last served
- Request sampled in IDLE at edge T: `sdram_stb` and `grant` are high from T+1.
- `sdram_ack` high in cycle N: `mX_ack` high in the same cycle N (combinational). At N+1, state is RELEASE and `sdram_stb` = 0.
- At N+2, state is IDLE. The earliest next `sdram_stb` is N+3.
- Minimum gap between transactions: 2 cycles with `sdram_stb` low. This lets the wrapper's 2-stage ack delay line clear.
- Masters follow classic handshake: deassert `stb` at the edge after `ack`.
- `rst_n` low at any edge: the FSM returns to IDLE and `sdram_stb` = 0 at that edge. An in-flight transaction is abandoned with no master ack.

## Configuration

- `SDRAM_ARB_RR_EN` defined:
  - Round-robin arbitration. On simultaneous requests in IDLE, the master not served last wins.
  - The last-served pointer updates on entry to BUSYx.
- `SDRAM_ARB_RR_EN` undefined:
  - Fixed priority; master 0 always wins a tie.
  - The pointer register is not implemented. Master 1 can starve.

## Test plan

- Reset, then `sdram_ready` = 0 with `m0_stb` = 1: `sdram_stb` stays 0 for 10 cycles. Raise `sdram_ready`: `sdram_stb` = 1 on the next cycle with `grant` = 01.
- M0 write: adr 0x12345, sel 10, wdat 0xA5C3; slave acks after 3 cycles. Check `sdram_adr` = 0x12345, `sdram_sel` = 10, `sdram_out` = 0xA5C3 held stable, and `m0_ack` a single cycle coincident with `sdram_ack`.
- M1 read with `sdram_dat` = 0x1F2E at ack: `m1_rdat` = 0x1F2E and `m1_ack` = 1 in the ack cycle; `m0_ack` stays 0.
- Both masters request continuously for 8 transactions:
  - With the RR macro: grants alternate 01, 10, 01, …
  - Without it: all 8 grants are 01.
  - Either way, `sdram_stb` is low for exactly 2 cycles between transactions.
- M0 drops `stb` one cycle into BUSY0: `sdram_stb` is held until `sdram_ack`, `m0_ack` stays 0, then RELEASE and IDLE.
- `rst_n` = 0 during BUSY1: `sdram_stb` = 0 and `grant` = 00 after that edge. No `m1_ack` is issued.
